fifo_sync_flags: RTL
====================

// Module: fifo_sync_flags
// PURPOSE
//  Parametrised single-clock FIFO; successor to the basic synchronous FIFO.
//  Adds non-power-of-two depth, selectable standard/first-word-fall-through read mode,
//  programmable almost-full/almost-empty thresholds, sticky overflow/underflow flags
//  and a synchronous flush. Used as a general data buffer between same-clock producers and consumers.
// PARAMETERS
//  WIDTH      8   data width in bits (>=1)
//  DEPTH      16  number of entries (>=2, any integer, not limited to powers of two)
//  AF_THRESH  12  almost_full asserts when count >= AF_THRESH (legal range 1..DEPTH)
//  AE_THRESH  2   almost_empty asserts when count <= AE_THRESH (legal range 0..DEPTH-1)
//  FWFT       0   0 = standard registered read; 1 = first-word-fall-through
//  CW         $clog2(DEPTH+1)  count width (derived; do not override)
// PORTS
//  clk           in   1      clock; all logic on the rising edge
//  rst_n         in   1      asynchronous reset, active low
//  flush         in   1      synchronous flush: empties the FIFO
//  wr_en         in   1      write request
//  din           in   WIDTH  write data
//  rd_en         in   1      read request (pop when FWFT=1)
//  dout          out  WIDTH  read data
//  dout_valid    out  1      dout holds valid read data
//  full          out  1      count == DEPTH
//  empty         out  1      count == 0
//  almost_full   out  1      count >= AF_THRESH
//  almost_empty  out  1      count <= AE_THRESH
//  count         out  CW     occupancy count, 0..DEPTH
//  overflow      out  1      sticky: write was attempted while full
//  underflow     out  1      sticky: read was attempted while empty
//  err_clr       in   1      clears overflow and underflow
// BEHAVIOUR
//  Reset (rst_n=0, async): wr_ptr, rd_ptr and count go to 0. dout=0, dout_valid=0, overflow=underflow=0.
//   Resulting flags: empty=1, full=0, almost_empty=1, almost_full=0. Memory contents are not reset.
//  Acceptance is evaluated on state before the edge:
//   wr_acc = wr_en & ~full
//   rd_acc = rd_en & ~empty
//   Write when full is rejected even if a read is accepted in the same cycle.
//   Read when empty is rejected even if a write is accepted in the same cycle.
//  Pointers advance by 1 on accept and wrap from DEPTH-1 to 0 (explicit compare; no modulo-2^n wrap).
//  count updates on the next edge: +1 on write only, -1 on read only, unchanged on both or neither.
//  Flags are combinational decodes of count.
//  FWFT=0: on rd_acc, dout <= mem[rd_ptr] with 1-cycle latency.
//   dout_valid is 1 for the cycle after each rd_acc, else 0. dout holds its value between reads.
//  FWFT=1: dout = mem[rd_ptr] combinationally; dout_valid = ~empty; rd_en acts as an acknowledge.
//   A word written into an empty FIFO appears on dout the cycle after the write.
//  overflow sets when wr_en & full. underflow sets when rd_en & empty.
//   err_clr clears both flags; if a set and err_clr occur in the same cycle, the set wins.
//  flush=1: on the next edge, pointers and count go to 0. Priority over wr_en and rd_en (both ignored).
//   FWFT=0: dout_valid goes to 0 and dout is held.
//   Flush does not affect overflow or underflow, and an ignored wr_en/rd_en during flush does not set them.
//  Reset asserted mid-operation aborts any in-flight access; the state after reset equals the post-reset state.
//  Elaboration must error if DEPTH<2 or either threshold is out of range.
// TESTING
//  1 DEPTH=5, FWFT=0: write 01..05 -> full=1, count=5.
//    Write AA -> rejected, overflow=1. Read x5 -> dout 01..05 in order, empty=1.
//  2 Wrap, DEPTH=5: 3 writes/3 reads, then 4 writes/4 reads -> data order preserved across the 4->0 wrap, count back to 0.
//  3 Simultaneous access:
//    count=2, wr+rd -> count stays 2.
//    Full, wr+rd -> count=4, overflow=1.
//    Empty, wr+rd -> count=1, underflow=1, dout_valid=0.
//  4 FWFT=1: write 3C into empty -> next cycle dout=3C, dout_valid=1 with no rd_en.
//    rd_en=1 for 1 cycle -> empty=1, dout_valid=0.
//  5 AF_THRESH=4, AE_THRESH=1, DEPTH=5: count 0..5 ->
//    almost_empty=1 only at 0,1; almost_full=1 only at 4,5.
//    err_clr together with wr_en&full -> overflow stays 1.
//  6 count=3: flush together with wr_en -> count=0, empty=1, overflow unchanged.
//    rst_n pulsed low mid-burst -> all outputs at reset values immediately.

Source files
------------

// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO with arbitrary depth, standard or first-word-fall-through read,
// threshold flags, sticky overflow/underflow and a synchronous flush.
module fifo_sync_flags #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = 12,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0,
  parameter int CW        = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow,
  input  logic             err_clr
);

  localparam int PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;

  if (DEPTH < 2) begin : g_bad_depth
    $error("fifo_sync_flags: DEPTH must be at least 2");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $error("fifo_sync_flags: AF_THRESH must lie in 1..DEPTH");
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
    $error("fifo_sync_flags: AE_THRESH must lie in 0..DEPTH-1");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             overflow_q, overflow_d, underflow_q, underflow_d;
  logic             full_s, empty_s, wr_acc_s, rd_acc_s, ovf_set_s, udf_set_s;

  assign full_s    = (count_q == CW'(DEPTH));
  assign empty_s   = (count_q == CW'(0));
  // Flush swallows both requests, so they neither move data nor raise error flags.
  assign wr_acc_s  = wr_en & ~full_s & ~flush;
  assign rd_acc_s  = rd_en & ~empty_s & ~flush;
  assign ovf_set_s = wr_en & full_s & ~flush;
  assign udf_set_s = rd_en & empty_s & ~flush;

  // Next-state for pointers, occupancy, registered read data and sticky errors.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc_s) begin
        wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (rd_acc_s) begin
        rd_ptr_d     = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        dout_d       = mem_q[rd_ptr_q];
        dout_valid_d = 1'b1;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({wr_acc_s, rd_acc_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
    // A new error event outranks a simultaneous clear.
    if (ovf_set_s) begin
      overflow_d = 1'b1;
    end else if (err_clr) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
    if (udf_set_s) begin
      underflow_d = 1'b1;
    end else if (err_clr) begin
      underflow_d = 1'b0;
    end else begin
      underflow_d = underflow_q;
    end
  end

  // Control and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  // Storage array; deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  assign dout         = (FWFT != 0) ? mem_q[rd_ptr_q] : dout_q;
  assign dout_valid   = (FWFT != 0) ? ~empty_s : dout_valid_q;
  assign full         = full_s;
  assign empty        = empty_s;
  assign almost_full  = (count_q >= CW'(AF_THRESH));
  assign almost_empty = (count_q <= CW'(AE_THRESH));
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule
